// File: rtl/fetch_pkg.sv
// Shared constants and FSM encoding for the SPI instruction fetch path.
package fetch_pkg;

    localparam logic [7:0]  SPI_CMD_READ = 8'h03;
    localparam int unsigned INSTR_W      = 18;
    localparam int unsigned ADDR_W       = 24;
    localparam int unsigned GAP_CYCLES   = 2;

    typedef enum logic [2:0] {
        ST_GAP,
        ST_CMD,
        ST_ADDR,
        ST_STREAM,
        ST_STALL
    } state_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO buffering fetched instructions; head is visible on dout.
module instr_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = INSTR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_instruction_fetch.sv
// Streams 18-bit instructions from SPI NOR flash (READ 0x03, mode 0) into a FIFO
// and hands them to the decoder one per cont_shift.
module spi_instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] START_ADDR = 24'h000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    input  logic               cont_shift,
    input  logic               spi_miso,
    output logic               spi_cs_n,
    output logic               spi_sclk,
    output logic               spi_mosi,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic               underrun,
    output logic               busy
);

    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [4:0] GAP_LAST   = 5'(GAP_CYCLES - 1);
    localparam logic [4:0] CMD_LAST   = 5'd7;
    localparam logic [4:0] ADDR_LAST  = 5'(ADDR_W - 1);
    localparam logic [4:0] WORD_LAST  = 5'(INSTR_W - 1);

    state_t             state_q, state_d;
    logic               phase_q, phase_d;
    logic [4:0]         bit_q, bit_d;
    logic [INSTR_W-1:0] sh_q, sh_d;
    logic               word_done_q;
    logic               pending_q;
    logic               underrun_q;
    logic               instr_valid_q;
    logic [INSTR_W-1:0] instruction_q;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty, full_next, bypass;
    logic [INSTR_W-1:0] fifo_dout;
    logic [CW-1:0]      fifo_count;

    assign fifo_push = word_done_q && !pending_q && !restart;
    assign fifo_pop  = cont_shift && !fifo_empty && !pending_q && !restart;
    assign bypass    = word_done_q && pending_q;
    // Count the word being pushed this cycle so a new word is never started without room.
    assign full_next = fifo_full ? !fifo_pop
                                 : (fifo_count == DEPTH_C - CW'(1)) && fifo_push && !fifo_pop;

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst || restart),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (sh_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        if (restart) begin
            state_d = ST_GAP;
            phase_d = 1'b0;
            bit_d   = '0;
        end else begin
            case (state_q)
                ST_GAP: begin
                    if (bit_q == GAP_LAST) begin
                        state_d = ST_CMD;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
                ST_CMD, ST_ADDR: begin
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        if (state_q == ST_CMD && bit_q == CMD_LAST) begin
                            state_d = ST_ADDR;
                            bit_d   = '0;
                        end else if (state_q == ST_ADDR && bit_q == ADDR_LAST) begin
                            state_d = ST_STREAM;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (!phase_q) begin
                        if (bit_q == '0 && full_next) begin
                            state_d = ST_STALL;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else begin
                        phase_d = 1'b0;
                        sh_d    = {sh_q[INSTR_W-2:0], spi_miso};
                        bit_d   = (bit_q == WORD_LAST) ? 5'd0 : bit_q + 5'd1;
                    end
                end
                ST_STALL: begin
                    // The stall replaces phase 0 of the first bit, so resume straight into phase 1.
                    if (!fifo_full) begin
                        state_d = ST_STREAM;
                        phase_d = 1'b1;
                    end
                end
                default: state_d = ST_GAP;
            endcase
        end
    end

    always_comb begin
        spi_mosi = 1'b0;
        case (state_q)
            ST_CMD:  spi_mosi = SPI_CMD_READ[~bit_q[2:0]];
            ST_ADDR: spi_mosi = START_ADDR[ADDR_LAST - bit_q];
            default: spi_mosi = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_GAP;
            phase_q       <= 1'b0;
            bit_q         <= '0;
            sh_q          <= '0;
            word_done_q   <= 1'b0;
            pending_q     <= 1'b0;
            underrun_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            instruction_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            word_done_q <= !restart && state_q == ST_STREAM && phase_q && bit_q == WORD_LAST;
            if (restart) begin
                pending_q     <= 1'b0;
                underrun_q    <= 1'b0;
                instr_valid_q <= 1'b0;
                instruction_q <= '0;
            end else begin
                if (cont_shift && fifo_empty) begin
                    underrun_q <= 1'b1;
                end
                if (bypass) begin
                    instruction_q <= sh_q;
                    instr_valid_q <= 1'b1;
                    pending_q     <= 1'b0;
                end else if (fifo_pop) begin
                    instruction_q <= fifo_dout;
                    instr_valid_q <= 1'b1;
                end else if (cont_shift && fifo_empty) begin
                    pending_q <= 1'b1;
                end
            end
        end
    end

    assign spi_cs_n    = (state_q == ST_GAP);
    assign spi_sclk    = phase_q;
    assign busy        = (state_q != ST_GAP);
    assign instruction = instruction_q;
    assign instr_valid = instr_valid_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_spi_instruction_fetch.sv
// Directed bench for spi_instruction_fetch with a behavioural SPI NOR flash model.
module tb_spi_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        cont_shift = 1'b0;
    logic        spi_miso = 1'b0;
    logic        spi_cs_n, spi_sclk, spi_mosi, instr_valid, underrun, busy;
    logic [17:0] instruction;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [17:0] words [8] = '{18'h0A1E3, 18'h3FF80, 18'h30000, 18'h15555,
                               18'h2AAAA, 18'h00001, 18'h20000, 18'h12345};

    int          rise_cnt = 0;
    int          fall_cnt = 0;
    logic        prev_sclk = 1'b0;
    logic [31:0] mosi_sr = '0;

    always #5 clk = ~clk;

    spi_instruction_fetch #(
        .FIFO_DEPTH (4),
        .START_ADDR (24'h000000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .restart     (restart),
        .cont_shift  (cont_shift),
        .spi_miso    (spi_miso),
        .spi_cs_n    (spi_cs_n),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .underrun    (underrun),
        .busy        (busy)
    );

    function automatic logic stream_bit(input int f);
        int          j;
        logic [17:0] w;
        if (f < 32) return 1'b0;
        j = f - 32;
        if (j / 18 >= 8) return 1'b0;
        w = words[j / 18];
        return w[17 - (j % 18)];
    endfunction

    // Flash model: shifts data on sclk falling edges, records MOSI on rising edges.
    always begin
        @(posedge clk);
        #1;
        if (spi_cs_n) begin
            rise_cnt  = 0;
            fall_cnt  = 0;
            prev_sclk = 1'b0;
            mosi_sr   = '0;
        end else begin
            if (spi_sclk && !prev_sclk) begin
                rise_cnt++;
                if (rise_cnt <= 32) mosi_sr = {mosi_sr[30:0], spi_mosi};
            end
            if (!spi_sclk && prev_sclk) fall_cnt++;
            prev_sclk = spi_sclk;
        end
        spi_miso = stream_bit(fall_cnt);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_rises(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (rise_cnt >= n) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic measure_startup(output int gap, output logic [31:0] mosi, output int lat);
        gap = 0;
        for (int i = 0; i < 10 && spi_cs_n; i++) begin
            gap++;
            tick();
        end
        lat = 0;
        while (rise_cnt < 33 && lat < 300) begin
            tick();
            lat++;
        end
        mosi = mosi_sr;
    endtask

    task automatic test_reset();
        int          gap, lat;
        logic [31:0] mosi;
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({spi_cs_n, spi_sclk, spi_mosi, instr_valid, underrun, busy} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b want=100000",
                     {spi_cs_n, spi_sclk, spi_mosi, instr_valid, underrun, busy});
        end
        vectors++;
        if (instruction !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_instr got=%h want=00000", instruction);
        end
        rst = 1'b0;
        measure_startup(gap, mosi, lat);
        vectors++;
        if (gap !== 2) begin
            miscompares++;
            $display("FAIL reset_gap got=%0d want=2", gap);
        end
        vectors++;
        if (mosi !== 32'h03000000) begin
            miscompares++;
            $display("FAIL reset_mosi got=%h want=03000000", mosi);
        end
        vectors++;
        if (lat !== 65) begin
            miscompares++;
            $display("FAIL reset_first_rise got=%0d want=65", lat);
        end
    endtask

    task automatic test_stream();
        bit ok;
        vectors++;
        if (instr_valid !== 1'b0 || instruction !== 18'h0) begin
            miscompares++;
            $display("FAIL stream_idle got=%b/%h want=0/00000", instr_valid, instruction);
        end
        for (int k = 0; k < 3; k++) begin
            wait_rises(32 + 18 * (k + 1), ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL stream_wait%0d got=timeout want=word", k);
            end
            repeat (2) tick();
            cont_shift = 1'b1;
            tick();
            cont_shift = 1'b0;
            vectors++;
            if (instruction !== words[k] || instr_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_word%0d got=%h/%b want=%h/1", k, instruction, instr_valid, words[k]);
            end
            tick();
            vectors++;
            if (instruction !== words[k]) begin
                miscompares++;
                $display("FAIL stream_hold%0d got=%h want=%h", k, instruction, words[k]);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (300) tick();
        vectors++;
        if (rise_cnt !== 104 || spi_sclk !== 1'b0 || spi_cs_n !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_full got=rises %0d sclk %b cs_n %b busy %b want=rises 104 sclk 0 cs_n 0 busy 1",
                     rise_cnt, spi_sclk, spi_cs_n, busy);
        end
        repeat (20) tick();
        vectors++;
        if (rise_cnt !== 104) begin
            miscompares++;
            $display("FAIL stall_hold got=%0d want=104", rise_cnt);
        end
        cont_shift = 1'b1;
        tick();
        cont_shift = 1'b0;
        vectors++;
        if (instruction !== words[0]) begin
            miscompares++;
            $display("FAIL stall_pop0 got=%h want=%h", instruction, words[0]);
        end
        n = 0;
        while (rise_cnt == 104 && n < 10) begin
            tick();
            n++;
        end
        vectors++;
        if (n > 1) begin
            miscompares++;
            $display("FAIL stall_resume got=%0d want<=1", n);
        end
        for (int w = 1; w < 8; w++) begin
            wait_rises(32 + 18 * (w + 1), ok);
            repeat (2) tick();
            cont_shift = 1'b1;
            tick();
            cont_shift = 1'b0;
            vectors++;
            if (!ok || instruction !== words[w]) begin
                miscompares++;
                $display("FAIL stall_word%0d got=%h ok=%b want=%h", w, instruction, ok, words[w]);
            end
        end
    endtask

    task automatic test_underrun();
        bit ok;
        rst = 1'b1;
        cont_shift = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        vectors++;
        if (underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_set got=%b want=1", underrun);
        end
        wait_rises(50, ok);
        tick();
        vectors++;
        if (!ok || instruction !== 18'h0) begin
            miscompares++;
            $display("FAIL underrun_early got=%h ok=%b want=00000", instruction, ok);
        end
        tick();
        vectors++;
        if (instruction !== 18'h0A1E3 || instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_bypass got=%h/%b want=0a1e3/1", instruction, instr_valid);
        end
        cont_shift = 1'b0;
        tick();
        vectors++;
        if (underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_sticky got=%b want=1", underrun);
        end
    endtask

    task automatic test_restart();
        bit          ok;
        int          gap, lat;
        logic [31:0] mosi;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        vectors++;
        if ({spi_cs_n, spi_sclk, instr_valid, underrun, busy} !== 5'b10000 || instruction !== 18'h0) begin
            miscompares++;
            $display("FAIL restart_clear got=%b/%h want=10000/00000",
                     {spi_cs_n, spi_sclk, instr_valid, underrun, busy}, instruction);
        end
        measure_startup(gap, mosi, lat);
        vectors++;
        if (gap !== 2 || mosi !== 32'h03000000 || lat !== 65) begin
            miscompares++;
            $display("FAIL restart_seq got=gap %0d mosi %h lat %0d want=gap 2 mosi 03000000 lat 65", gap, mosi, lat);
        end
        wait_rises(50, ok);
        repeat (2) tick();
        cont_shift = 1'b1;
        tick();
        cont_shift = 1'b0;
        vectors++;
        if (!ok || instruction !== words[0]) begin
            miscompares++;
            $display("FAIL restart_pop0 got=%h want=%h", instruction, words[0]);
        end
        wait_rises(60, ok);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        vectors++;
        if (!ok || instruction !== 18'h0 || instr_valid !== 1'b0 || spi_cs_n !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_mid got=%h/%b/%b want=00000/0/1", instruction, instr_valid, spi_cs_n);
        end
        measure_startup(gap, mosi, lat);
        vectors++;
        if (gap !== 2 || mosi !== 32'h03000000 || lat !== 65) begin
            miscompares++;
            $display("FAIL restart_reseq got=gap %0d mosi %h lat %0d want=gap 2 mosi 03000000 lat 65", gap, mosi, lat);
        end
        wait_rises(50, ok);
        repeat (3) tick();
        vectors++;
        if (!ok || instr_valid !== 1'b0 || instruction !== 18'h0) begin
            miscompares++;
            $display("FAIL restart_quiet got=%h/%b want=00000/0", instruction, instr_valid);
        end
        cont_shift = 1'b1;
        tick();
        cont_shift = 1'b0;
        vectors++;
        if (instruction !== words[0]) begin
            miscompares++;
            $display("FAIL restart_refetch0 got=%h want=%h", instruction, words[0]);
        end
        wait_rises(68, ok);
        repeat (2) tick();
        cont_shift = 1'b1;
        tick();
        cont_shift = 1'b0;
        vectors++;
        if (!ok || instruction !== words[1]) begin
            miscompares++;
            $display("FAIL restart_refetch1 got=%h want=%h", instruction, words[1]);
        end
    endtask

    task automatic test_rst_mid();
        bit          ok;
        int          gap, lat;
        logic [31:0] mosi;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        cont_shift = 1'b1;
        tick();
        cont_shift = 1'b0;
        vectors++;
        if (underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_underrun got=%b want=1", underrun);
        end
        wait_rises(12, ok);
        rst = 1'b1;
        tick();
        vectors++;
        if (!ok || {spi_cs_n, spi_sclk, spi_mosi, instr_valid, underrun, busy} !== 6'b100000
                || instruction !== 18'h0) begin
            miscompares++;
            $display("FAIL rstmid_outputs got=%b/%h want=100000/00000",
                     {spi_cs_n, spi_sclk, spi_mosi, instr_valid, underrun, busy}, instruction);
        end
        rst = 1'b0;
        measure_startup(gap, mosi, lat);
        vectors++;
        if (gap !== 2 || mosi !== 32'h03000000 || lat !== 65) begin
            miscompares++;
            $display("FAIL rstmid_seq got=gap %0d mosi %h lat %0d want=gap 2 mosi 03000000 lat 65", gap, mosi, lat);
        end
        wait_rises(50, ok);
        repeat (3) tick();
        vectors++;
        if (!ok || instr_valid !== 1'b0 || underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_nopending got=%b/%b want=0/0", instr_valid, underrun);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_underrun();
        test_restart();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
